// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: opcode constants, field positions and decoded-operand record shared by the ISA front end
package cpu_isa_pkg;
  localparam int OPC_W = 6;
  localparam int RA_W = 5;
  localparam int FA_LSB = 21;
  localparam int FB_LSB = 16;
  localparam int FC_LSB = 11;
  localparam logic [OPC_W-1:0] OP_LI = 6'b111001;
  localparam logic [OPC_W-1:0] OP_LUI = 6'b111010;
  localparam logic [OPC_W-1:0] OP_LWI = 6'b111011;
  localparam logic [OPC_W-1:0] OP_SWI = 6'b111100;
  localparam logic [OPC_W-1:0] OP_LW = 6'b111101;
  localparam logic [OPC_W-1:0] OP_SW = 6'b111110;
  localparam logic [1:0] BR_PREFIX = 2'b10;
  typedef struct packed {
    logic [RA_W-1:0] rr1;
    logic [RA_W-1:0] rr2;
    logic use1;
    logic use2;
    logic wr;
    logic [RA_W-1:0] wa;
  } operand_t;
endpackage

// File: rtl/ir_operand_decode.sv
// ir_operand_decode: instruction word to read/write register operands; unused fields read as zero
module ir_operand_decode
  import cpu_isa_pkg::*;
#(
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] ir,
  output operand_t           op_out
);
  localparam logic [RA_W-1:0] Z = '0;
  logic [OPC_W-1:0] op;
  logic [RA_W-1:0] ra, rb, rc;
  logic unused_bits;
  assign op = ir[INSTR_W-1 -: OPC_W];
  assign ra = ir[FA_LSB +: RA_W];
  assign rb = ir[FB_LSB +: RA_W];
  assign rc = ir[FC_LSB +: RA_W];
  assign unused_bits = ^ir[FC_LSB-1:0];
  // record layout: {rr1, rr2, use1, use2, wr, wa}
  always_comb begin
    op_out = '0;
    if (op[OPC_W-1 -: 2] == BR_PREFIX) op_out = {ra, rb, 3'b110, Z};
    else
      case (op)
        OP_LI, OP_LUI: op_out = {ra, rb, 3'b111, ra};
        OP_LWI:        op_out = {ra, Z, 3'b101, ra};
        OP_LW:         op_out = {Z, rb, 3'b011, ra};
        OP_SWI:        op_out = {Z, ra, 3'b010, Z};
        OP_SW:         op_out = {rb, ra, 3'b110, Z};
        default:       op_out = {rb, rc, 3'b111, ra};
      endcase
  end
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: decode, scoreboard RAW stall and 1-entry valid/ready output register
module operand_fetch_stage
  import cpu_isa_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  parameter int WB_BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [INSTR_W-1:0]    in_ir,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INSTR_W-1:0]    out_ir,
  output logic [REG_ADDR_W-1:0] out_rr1,
  output logic [REG_ADDR_W-1:0] out_rr2,
  output logic                  out_use1,
  output logic                  out_use2,
  output logic                  out_wr,
  output logic [REG_ADDR_W-1:0] out_wa,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic                  flush,
  output logic [NUM_REGS-1:0]   busy_vec
);
  operand_t dec;
  logic [REG_ADDR_W-1:0] src [2];
  logic [1:0] src_use, hz;
  logic accept, out_fire;
  logic [NUM_REGS-1:0] set_vec, clr_vec;
  ir_operand_decode #(.INSTR_W(INSTR_W)) u_dec (.ir(in_ir), .op_out(dec));
  assign src[0] = dec.rr1;
  assign src[1] = dec.rr2;
  assign src_use = {dec.use2, dec.use1};
  // a source blocks while its write is recorded (unless retiring now) or still sitting in the output register
  for (genvar i = 0; i < 2; i++) begin : g_src
    assign hz[i] = src_use[i] && !((ZERO_REG != 0) && src[i] == '0) &&
                   ((busy_vec[src[i]] && !((WB_BYPASS != 0) && wb_valid && wb_addr == src[i])) ||
                    (out_valid && out_wr && out_wa == src[i]));
  end
  assign in_ready = !reset && !flush && !(|hz) && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign out_fire = out_valid && out_ready && !flush;
  assign set_vec = (out_fire && out_wr && !((ZERO_REG != 0) && out_wa == '0)) ? NUM_REGS'(1) << out_wa : '0;
  assign clr_vec = wb_valid ? NUM_REGS'(1) << wb_addr : '0;
  always_ff @(posedge clk) begin
    busy_vec <= reset ? '0 : (busy_vec & ~clr_vec) | set_vec;
    if (reset) {out_valid, out_ir, out_rr1, out_rr2, out_use1, out_use2, out_wr, out_wa} <= '0;
    else begin
      out_valid <= !flush && (accept || (out_valid && !out_fire));
      if (accept) {out_ir, out_rr1, out_rr2, out_use1, out_use2, out_wr, out_wa} <= {in_ir, dec};
    end
  end
endmodule
